// File: rtl/gru_sequencer.sv
// gru_sequencer: control FSM that walks one shared MAC/accumulator datapath
// through a full GRU layer update. Gates are processed g-major (z, r, h) and
// unit-minor; each unit is bias load, M input MACs, N recurrent MACs, one write.
module gru_sequencer #(
  parameter int M      = 24,
  parameter int N      = 24,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [1:0]        gate,
  output logic [7:0]        unit_idx,
  output logic [7:0]        vec_idx,
  output logic [9:0]        bias_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_sel,
  output logic              acc_load,
  output logic              acc_en,
  output logic              use_reset,
  output logic              gate_we
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BIAS = 3'd1,
    INP  = 3'd2,
    REC  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0]        M_LAST      = 8'(M - 1);
  localparam logic [7:0]        N_LAST      = 8'(N - 1);
  localparam logic [1:0]        G_LAST      = 2'd2;
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(3 * N);
  localparam logic [ADDR_W-1:0] GATE_STRIDE = ADDR_W'(N);
  localparam logic [9:0]        BIAS_STRIDE = 10'(N);

  state_t state_q, state_d;
  logic [1:0] g_q, g_d;
  logic [7:0] j_q, j_d;
  logic [7:0] c_q, c_d;

  logic              active;
  logic [ADDR_W-1:0] mac_addr;
  logic [9:0]        bias_sum;

  // Sequencing registers; reset dominates start and stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      j_q     <= 8'd0;
      c_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      j_q     <= j_d;
      c_q     <= c_d;
    end
  end

  // Next-state and counter advance; a stall freezes every layer state
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    j_d     = j_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BIAS;
          g_d     = 2'd0;
          j_d     = 8'd0;
          c_d     = 8'd0;
        end
      end
      BIAS: begin
        if (!stall) begin
          state_d = INP;
          c_d     = 8'd0;
        end
      end
      INP: begin
        if (!stall) begin
          if (c_q == M_LAST) begin
            state_d = REC;
            c_d     = 8'd0;
          end else begin
            c_d = c_q + 8'd1;
          end
        end
      end
      REC: begin
        if (!stall) begin
          if (c_q == N_LAST) begin
            state_d = WR;
            c_d     = 8'd0;
          end else begin
            c_d = c_q + 8'd1;
          end
        end
      end
      WR: begin
        if (!stall) begin
          if (j_q != N_LAST) begin
            state_d = BIAS;
            j_d     = j_q + 8'd1;
          end else if (g_q != G_LAST) begin
            state_d = BIAS;
            g_d     = g_q + 2'd1;
            j_d     = 8'd0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        g_d     = 2'd0;
        j_d     = 8'd0;
        c_d     = 8'd0;
      end
      default: begin
        state_d = IDLE;
        g_d     = 2'd0;
        j_d     = 8'd0;
        c_d     = 8'd0;
      end
    endcase
  end

  // Address arithmetic from registered counters only, so stalls hold it steady
  always_comb begin
    active   = (state_q == BIAS) || (state_q == INP) ||
               (state_q == REC)  || (state_q == WR);
    mac_addr = ADDR_W'(c_q) * ROW_STRIDE + ADDR_W'(g_q) * GATE_STRIDE + ADDR_W'(j_q);
    bias_sum = 10'(g_q) * BIAS_STRIDE + 10'(j_q);
  end

  // Output decode; strobes are the only outputs that see stall combinationally
  always_comb begin
    busy      = active;
    done      = 1'b0;
    gate      = active ? g_q : 2'd0;
    unit_idx  = active ? j_q : 8'd0;
    bias_addr = active ? bias_sum : 10'd0;
    vec_idx   = 8'd0;
    w_addr    = '0;
    w_sel     = 1'b0;
    acc_load  = 1'b0;
    acc_en    = 1'b0;
    use_reset = 1'b0;
    gate_we   = 1'b0;
    case (state_q)
      BIAS: acc_load = !stall;
      INP: begin
        acc_en  = !stall;
        vec_idx = c_q;
        w_addr  = mac_addr;
      end
      REC: begin
        acc_en    = !stall;
        vec_idx   = c_q;
        w_addr    = mac_addr;
        w_sel     = 1'b1;
        use_reset = (g_q == G_LAST);
      end
      WR:   gate_we = !stall;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/gru_sequencer.md
# gru_sequencer

Control FSM that drives one shared MAC/accumulator datapath through a full GRU layer update. It generates the bias, weight and vector addresses, the accumulator strobes and the gate write strobes. The order is: update gate z for all units, then reset gate r for all units, then candidate/output h for all units. It sits between the frame controller (start/done) and the GRU datapath (weight ROMs, accumulator, sigmoid/tanh LUTs, z/r/h registers). One instance per GRU layer: vad 24→24, noise 90→48, denoise 114→96.

## Interface
- M, default 24: input vector length, range 1..255
- N, default 24: unit count / state length, range 1..255
- ADDR_W, default 16: weight address width; must satisfy max(M,N)·3N ≤ 2^ADDR_W
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request one layer update; sampled only in IDLE
- stall  in  1  datapath/LUT not ready; freezes sequencing
- busy  out  1  high in BIAS, INP, REC and WR states
- done  out  1  one-cycle pulse in DONE state
- gate  out  2  current gate: 0=z, 1=r, 2=h (3 never driven)
- unit_idx  out  8  current unit j
- vec_idx  out  8  current i (INP state) or k (REC state); 0 otherwise
- bias_addr  out  10  g·N + j
- w_addr  out  ADDR_W  i·3N + g·N + j in INP; k·3N + g·N + j in REC; 0 otherwise
- w_sel  out  1  0 = input weights/input vector, 1 = recurrent weights/state
- acc_load  out  1  load accumulator with bias (BIAS state)
- acc_en  out  1  accumulate weight·operand (INP/REC states)
- use_reset  out  1  high in REC when gate=2; datapath multiplies state[k] by r[k]
- gate_we  out  1  write scaled accumulator through activation into gate register[gate][unit_idx]

## Operation
- States: IDLE, BIAS, INP, REC, WR, DONE. Registers: state, g (2b), j, c (inner counter, 8b).
- IDLE: all outputs 0. If start=1, go to BIAS with g=0, j=0, c=0.
- BIAS: acc_load=1. Next state INP, c=0.
- INP: acc_en=1, w_sel=0, vec_idx=c. If c=M−1, go to REC with c=0; else c+1.
- REC: acc_en=1, w_sel=1, vec_idx=c, use_reset=(g==2). If c=N−1, go to WR; else c+1.
- WR: gate_we=1.
  - If j<N−1: j+1, go to BIAS.
  - Else if g<2: g+1, j=0, go to BIAS.
  - Else go to DONE.
- DONE: done=1, busy=0. Next state IDLE unconditionally. start in DONE is ignored.
- All gate-z and gate-r writes complete before any h accumulation, because h needs r for every k.
- Address arithmetic uses unsigned, ADDR_W bits, computed from registered counters. No wrap is permitted within legal parameters.

## Timing
- Outputs decode combinationally from the registered state and counters. No output depends combinationally on start or stall, except that the strobes are masked by stall.
- start sampled high at edge t0 → first BIAS cycle is t0+1.
- Cycles per unit = M+N+2. Busy cycles = 3N(M+N+2).
- done is high on cycle t0+1+3N(M+N+2). IDLE follows on the next cycle, so the earliest next start is sampled one cycle after done.
- Stall: while stall=1 in BIAS/INP/REC/WR:
  - state and counters hold
  - acc_load, acc_en and gate_we are forced 0
  - address, index, gate, w_sel and use_reset outputs hold their values
  - each stalled cycle extends the total by exactly 1
  - stall in IDLE or DONE has no effect
- start while busy or in DONE: ignored, not queued.
- Reset: rst_n=0 at any edge → state IDLE, g=j=c=0, all outputs 0 from the next cycle. Reset wins over start and stall in the same cycle.
- gate_we is asserted exactly 3N times per run, once per (g, j) pair, in order g-major then j.

## Test plan
- M=3, N=2, start pulse at t0, no stall → busy for t0+1..t0+42; done=1 only at t0+43; 6 gate_we pulses; 6 acc_load pulses; 30 acc_en cycles.
- M=3, N=2, address check → at g=1, j=1, INP c=2: w_addr=15, bias_addr=3, w_sel=0. At g=2, j=0, REC c=1: w_addr=10, use_reset=1.
- Default M=N=24 → done exactly 3600 cycles after the first BIAS cycle; max w_addr reached is 23·72+71=1727.
- Stall held for 5 cycles mid-INP → counters and w_addr frozen; acc_en=0 for those 5 cycles; done delayed by exactly 5 cycles; stall asserted during IDLE has no effect.
- start re-pulsed during busy and on the done cycle → no restart, total cycle count unchanged. A start one cycle after done → new run begins normally.
- rst_n=0 for one cycle during REC of g=2 → next cycle all outputs 0 in IDLE, with no done pulse. A subsequent start runs a complete fresh sequence from g=0, j=0.
